// File: rtl/rv32_icache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped RV32 instruction cache.
// Address-field width helpers, controller state encoding and reset values.
package rv32_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } icache_state_t;

    function automatic int wo_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int ix_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers everything above the byte, word and index fields.
    function automatic int tag_bits(input int lines, input int words_per_line);
        return 30 - $clog2(words_per_line) - $clog2(lines);
    endfunction

    localparam logic [31:0] RST_RDATA   = 32'h0000_0000;
    localparam logic [31:0] RST_ADDR    = 32'h0000_0000;
    localparam logic        RST_VALID   = 1'b0;
    localparam logic        RST_STALL   = 1'b0;
    localparam logic        RST_MEM_REQ = 1'b0;

endpackage

// File: rtl/rv32_icache_ctrl_if.sv
// CPU fetch port, invalidate strobe and refill memory port of the instruction cache.
// slave = cache controller side, master = CPU plus backing memory side.
interface rv32_icache_ctrl_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, inv, mem_ack, mem_rdata,
        output cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, inv, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_valid, cpu_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/rv32_icache_ctrl_tag_store.sv
// Valid bits and tags for the instruction cache: combinational hit compare,
// single-cycle bulk invalidate and per-line tag write at the end of a refill.
module rv32_icache_tag_store #(
    parameter int LINES = 16,
    parameter int IX    = 4,
    parameter int TW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IX-1:0] lookup_index,
    input  logic [TW-1:0] lookup_tag,
    output logic          hit,
    input  logic          inv,
    input  logic          wr_en,
    input  logic [IX-1:0] wr_index,
    input  logic [TW-1:0] wr_tag,
    input  logic          wr_valid
);

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];

    // A write in the same cycle as inv still lands; the caller drops wr_valid then.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inv)
                valid <= '0;
            if (wr_en)
                valid[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            tags[wr_index] <= wr_tag;
    end

    assign hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/rv32_icache_ctrl.sv
// Direct-mapped read-only instruction cache controller with word-per-beat refill.
// Define ICACHE_STATS_EN to add the hit_count / miss_count lookup counters.
module rv32_icache_ctrl
    import rv32_cache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               rst,
    rv32_icache_ctrl_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int WO = wo_bits(WORDS_PER_LINE);
    localparam int IX = ix_bits(LINES);
    localparam int TW = tag_bits(LINES, WORDS_PER_LINE);
    localparam logic [WO-1:0] LAST_BEAT = WO'(WORDS_PER_LINE - 1);

    icache_state_t state, state_nxt;

    logic [WO-1:0]   beat;
    logic [WO-1:0]   req_word;
    logic [29-WO:0]  line_hi;
    logic            poisoned;
    logic            hit_q;
    logic [31:0]     rdata_q;
    logic [31:0]     data_mem [LINES*WORDS_PER_LINE];

    logic [IX-1:0]   cpu_index;
    logic [WO-1:0]   cpu_word;
    logic [TW-1:0]   cpu_tag;
    logic [IX-1:0]   fill_index;
    logic            tag_hit;
    logic            lookup;
    logic            lookup_hit;
    logic            lookup_miss;
    logic            beat_done;
    logic            last_beat;
    logic            unused_addr_bits;

    assign cpu_word         = bus.cpu_addr[2 +: WO];
    assign cpu_index        = bus.cpu_addr[2+WO +: IX];
    assign cpu_tag          = bus.cpu_addr[31 -: TW];
    assign fill_index       = line_hi[IX-1:0];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    // inv in the lookup cycle forces a miss so the line is refetched.
    assign lookup      = (state == IDLE) && bus.cpu_req;
    assign lookup_hit  = lookup && tag_hit && !bus.inv;
    assign lookup_miss = lookup && !lookup_hit;
    assign beat_done   = (state == REFILL) && bus.mem_ack;
    assign last_beat   = beat_done && (beat == LAST_BEAT);

    rv32_icache_tag_store #(
        .LINES (LINES),
        .IX    (IX),
        .TW    (TW)
    ) u_tag_store (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (cpu_index),
        .lookup_tag   (cpu_tag),
        .hit          (tag_hit),
        .inv          (bus.inv),
        .wr_en        (last_beat),
        .wr_index     (fill_index),
        .wr_tag       (line_hi[IX +: TW]),
        .wr_valid     (!(poisoned || bus.inv))
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (lookup_miss) state_nxt = REFILL;
            REFILL:  if (last_beat)   state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            req_word <= '0;
            line_hi  <= '0;
            poisoned <= 1'b0;
            hit_q    <= RST_VALID;
            rdata_q  <= RST_RDATA;
        end else begin
            hit_q <= lookup_hit;
            if (lookup_hit)
                rdata_q <= data_mem[{cpu_index, cpu_word}];
            if (lookup_miss) begin
                line_hi  <= bus.cpu_addr[31:2+WO];
                req_word <= cpu_word;
                beat     <= '0;
                poisoned <= 1'b0;
            end
            if ((state == REFILL) && bus.inv)
                poisoned <= 1'b1;
            if (beat_done) begin
                beat <= beat + WO'(1);
                if (beat == req_word)
                    rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_done)
            data_mem[{fill_index, beat}] <= bus.mem_rdata;
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_valid = hit_q || (state == RESPOND);
    assign bus.cpu_stall = (state == REFILL) ? 1'b1 : RST_STALL;
    assign bus.mem_req   = (state == REFILL) ? 1'b1 : RST_MEM_REQ;
    assign bus.mem_addr  = (state == REFILL) ? {line_hi, beat, 2'b00} : RST_ADDR;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit)
                hit_count <= hit_count + 32'd1;
            if (lookup_miss)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_icache_ctrl.sv
// Directed bench for rv32_icache_ctrl: misses, hits, conflicts, ack gaps, inv and reset.
// Backing memory returns 0x9C + word address, so 0x10 -> 0xA0, 0x14 -> 0xA1, ...
module tb_rv32_icache_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rv32_icache_ctrl_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    rv32_icache_ctrl #(
        .LINES          (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          r_cycles;
    int          r_stalls;
    int          r_beats;
    int          r_ntrace;
    logic [31:0] r_rdata;
    logic [31:0] r_trace [16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_009C + {2'b00, a[31:2]};
    endfunction

    // Issues one request and plays the backing memory until cpu_valid (cycle count
    // is measured from the request cycle). pat gives per-refill-cycle ack bits,
    // continuous ack after pat_len; inv is pulsed at loop cycle inv_at (0 = with request).
    task automatic run_access(input logic [31:0] addr, input logic [15:0] pat,
                              input int pat_len, input int inv_at);
        int  k;
        int  p;
        bit  done;
        bit  a;
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        bus.inv      = (inv_at == 0);
        r_cycles = -1;
        r_stalls = 0;
        r_beats  = 0;
        r_ntrace = 0;
        r_rdata  = 32'hDEAD_BEEF;
        k = 0;
        p = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            bus.mem_ack = 1'b0;
            bus.inv     = (k == inv_at);
            if (bus.cpu_valid) begin
                r_rdata     = bus.cpu_rdata;
                r_cycles    = k;
                bus.cpu_req = 1'b0;
                done        = 1'b1;
            end else begin
                if (bus.cpu_stall)
                    r_stalls++;
                if (bus.mem_req) begin
                    if (r_ntrace < 16)
                        r_trace[r_ntrace] = bus.mem_addr;
                    r_ntrace++;
                    a = (p < pat_len) ? pat[p] : 1'b1;
                    p++;
                    if (a) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_word(bus.mem_addr);
                        r_beats++;
                    end
                end
            end
        end
        bus.inv     = 1'b0;
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_cpu_valid: got %b want 0", bus.cpu_valid); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", bus.cpu_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        run_access(32'h0000_0010, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL cold_latency: got %0d want 5", r_cycles); end
        checks++; if (r_stalls !== 4) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 4", r_stalls); end
        checks++; if (r_rdata !== 32'hA0) begin errors++; $display("FAIL cold_rdata: got %h want a0", r_rdata); end
        checks++; if (r_ntrace !== 4) begin errors++; $display("FAIL cold_beats: got %0d want 4", r_ntrace); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_trace[i] !== exp_addr[i]) begin
                errors++; $display("FAIL cold_mem_addr[%0d]: got %h want %h", i, r_trace[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_hit();
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0014;
        @(negedge clk);
        checks++; if (bus.cpu_valid !== 1'b1) begin errors++; $display("FAIL hit0_valid: got %b want 1", bus.cpu_valid); end
        checks++; if (bus.cpu_rdata !== 32'hA1) begin errors++; $display("FAIL hit0_rdata: got %h want a1", bus.cpu_rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL hit0_mem_req: got %b want 0", bus.mem_req); end
        bus.cpu_addr = 32'h0000_001C;
        @(negedge clk);
        checks++; if (bus.cpu_valid !== 1'b1) begin errors++; $display("FAIL hit1_valid: got %b want 1", bus.cpu_valid); end
        checks++; if (bus.cpu_rdata !== 32'hA3) begin errors++; $display("FAIL hit1_rdata: got %h want a3", bus.cpu_rdata); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL hit1_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL hit1_stall: got %b want 0", bus.cpu_stall); end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_conflict();
        run_access(32'h0000_0110, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL conflict_miss_latency: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hE0) begin errors++; $display("FAIL conflict_rdata: got %h want e0", r_rdata); end
        checks++; if (r_trace[0] !== 32'h110) begin errors++; $display("FAIL conflict_base: got %h want 110", r_trace[0]); end
        run_access(32'h0000_0010, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL evicted_latency: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hA0) begin errors++; $display("FAIL evicted_rdata: got %h want a0", r_rdata); end
    endtask

    task automatic test_ack_gaps();
        logic [31:0] exp_addr [7];
        exp_addr = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h28, 32'h2C, 32'h2C};
        run_access(32'h0000_0028, 16'h0059, 7, -1);
        checks++; if (r_cycles !== 8) begin errors++; $display("FAIL gap_latency: got %0d want 8", r_cycles); end
        checks++; if (r_stalls !== 7) begin errors++; $display("FAIL gap_stall_cycles: got %0d want 7", r_stalls); end
        checks++; if (r_beats !== 4) begin errors++; $display("FAIL gap_acked_beats: got %0d want 4", r_beats); end
        checks++; if (r_rdata !== 32'hA6) begin errors++; $display("FAIL gap_rdata: got %h want a6", r_rdata); end
        checks++; if (r_ntrace !== 7) begin errors++; $display("FAIL gap_req_cycles: got %0d want 7", r_ntrace); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (r_trace[i] !== exp_addr[i]) begin
                errors++; $display("FAIL gap_mem_addr[%0d]: got %h want %h", i, r_trace[i], exp_addr[i]);
            end
        end
        run_access(32'h0000_0020, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1 || r_rdata !== 32'hA4) begin errors++; $display("FAIL gap_word0: got %0d cycles data %h want 1 cycle data a4", r_cycles, r_rdata); end
        run_access(32'h0000_002C, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1 || r_rdata !== 32'hA7) begin errors++; $display("FAIL gap_word3: got %0d cycles data %h want 1 cycle data a7", r_cycles, r_rdata); end
    endtask

    task automatic test_inv();
        run_access(32'h0000_0014, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1) begin errors++; $display("FAIL inv_prehit_latency: got %0d want 1", r_cycles); end
        @(negedge clk);
        bus.inv = 1'b1;
        @(negedge clk);
        bus.inv = 1'b0;
        run_access(32'h0000_0014, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL inv_pulse_miss: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hA1) begin errors++; $display("FAIL inv_pulse_rdata: got %h want a1", r_rdata); end
        run_access(32'h0000_0018, 16'h0, 0, 0);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL inv_with_req_miss: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hA2) begin errors++; $display("FAIL inv_with_req_rdata: got %h want a2", r_rdata); end
        run_access(32'h0000_0030, 16'h0, 0, 2);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL inv_mid_latency: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hA8) begin errors++; $display("FAIL inv_mid_rdata: got %h want a8", r_rdata); end
        run_access(32'h0000_0034, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL poisoned_line_miss: got %0d want 5", r_cycles); end
        checks++; if (r_rdata !== 32'hA9) begin errors++; $display("FAIL poisoned_refill_rdata: got %h want a9", r_rdata); end
        run_access(32'h0000_0038, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1 || r_rdata !== 32'hAA) begin errors++; $display("FAIL refilled_hit: got %0d cycles data %h want 1 cycle data aa", r_cycles, r_rdata); end
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0040;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL rstmid_beat1_addr: got %h want 44", bus.mem_addr); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", bus.cpu_stall); end
        checks++; if (bus.cpu_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.cpu_valid); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", bus.cpu_rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_mem_addr: got %h want 0", bus.mem_addr); end
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
        rst         = 1'b0;
        bus.cpu_req = 1'b0;
        run_access(32'h0000_0040, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5 || r_rdata !== 32'hAC) begin errors++; $display("FAIL rstmid_refetch: got %0d cycles data %h want 5 cycles data ac", r_cycles, r_rdata); end
        run_access(32'h0000_0010, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5 || r_rdata !== 32'hA0) begin errors++; $display("FAIL rstmid_all_invalid: got %0d cycles data %h want 5 cycles data a0", r_cycles, r_rdata); end
        run_access(32'h0000_0044, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1 || r_rdata !== 32'hAD) begin errors++; $display("FAIL rstmid_hit44: got %0d cycles data %h want 1 cycle data ad", r_cycles, r_rdata); end
        run_access(32'h0000_0014, 16'h0, 0, -1);
        checks++; if (r_cycles !== 1 || r_rdata !== 32'hA1) begin errors++; $display("FAIL rstmid_hit14: got %0d cycles data %h want 1 cycle data a1", r_cycles, r_rdata); end
        run_access(32'h0000_0080, 16'h0, 0, -1);
        checks++; if (r_cycles !== 5 || r_rdata !== 32'hBC) begin errors++; $display("FAIL rstmid_miss80: got %0d cycles data %h want 5 cycles data bc", r_cycles, r_rdata); end
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL stats_hits: got %0d want 2", hit_count); end
        checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL stats_misses: got %0d want 3", miss_count); end
`endif
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.inv       = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_ack_gaps();
        test_inv();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
